// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                              |
// | Shared state encoding and default sizing for the UART TX arbiter.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package uart_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int MAX_BURST_DEF = 4;
   localparam int BURST_W       = 4;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_ACK  = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if                                                    |
// | Requester byte streams plus transmitter handshake bundle.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) ();

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_cts;
   logic                 tx_busy;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 grant_active;
   logic [ID_W-1:0]      grant_id;

   modport master (
      output req_valid, req_data, req_last, uart_cts, tx_busy,
      input  req_ready, tx_start, tx_data, grant_active, grant_id
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_cts, tx_busy,
      output req_ready, tx_start, tx_data, grant_active, grant_id
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Combinational round-robin pick, searching from last_grant+1 upward.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  wire logic [NUM_REQ-1:0] req_i,
   input  wire logic [ID_W-1:0]    last_grant_i,
   output logic      [ID_W-1:0]    winner_o,
   output logic                    any_req_o
);

   // Walk from farthest to nearest so the nearest requester overwrites.
   always_comb begin
      int idx;
      idx       = 0;
      winner_o  = '0;
      any_req_o = |req_i;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = (int'(last_grant_i) + off) % NUM_REQ;
         if (req_i[idx]) begin
            winner_o = ID_W'(idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                       |
// | Shares one UART transmitter among NUM_REQ byte streams, with bursts.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input wire logic          clk,
   input wire logic          rst,
   uart_tx_arbiter_if.slave  bus
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam logic [BURST_W-1:0] c_max_burst = BURST_W'(MAX_BURST);
   localparam logic [ID_W-1:0]    c_last_rst  = ID_W'(NUM_REQ - 1);

   state_t               state_q, state_d;
   logic [ID_W-1:0]      grant_id_q, grant_id_d;
   logic [ID_W-1:0]      last_grant_q, last_grant_d;
   logic                 grant_active_q, grant_active_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic                 last_q, last_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;

   logic [ID_W-1:0]      w_winner;
   logic                 w_any;
   logic                 w_accept;
   logic [7:0]           w_byte;
   logic [NUM_REQ-1:0]   w_req_ready;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i        (bus.req_valid),
      .last_grant_i (last_grant_q),
      .winner_o     (w_winner),
      .any_req_o    (w_any)
   );

   assign w_byte   = bus.req_data[{grant_id_q, 3'b000} +: 8];
   assign w_accept = (state_q == S_SEND) && bus.req_valid[grant_id_q]
                     && bus.uart_cts && !bus.tx_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         grant_id_q     <= '0;
         last_grant_q   <= c_last_rst;
         grant_active_q <= 1'b0;
         burst_q        <= '0;
         last_q         <= 1'b0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
      end else begin
         state_q        <= state_d;
         grant_id_q     <= grant_id_d;
         last_grant_q   <= last_grant_d;
         grant_active_q <= grant_active_d;
         burst_q        <= burst_d;
         last_q         <= last_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_id_d     = grant_id_q;
      last_grant_d   = last_grant_q;
      grant_active_d = grant_active_q;
      burst_d        = burst_q;
      last_d         = last_q;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (w_any && bus.uart_cts) begin
               grant_id_d     = w_winner;
               grant_active_d = 1'b1;
               burst_d        = '0;
               state_d        = S_SEND;
            end
         end
         S_SEND: begin
            // An empty owner gives up the grant; flow-off alone only stalls.
            if (!bus.req_valid[grant_id_q]) begin
               last_grant_d   = grant_id_q;
               grant_active_d = 1'b0;
               state_d        = S_IDLE;
            end else if (w_accept) begin
               tx_data_d  = w_byte;
               tx_start_d = 1'b1;
               last_d     = bus.req_last[grant_id_q];
               burst_d    = burst_q + 4'd1;
               state_d    = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (last_q || (burst_q == c_max_burst)) begin
                  last_grant_d   = grant_id_q;
                  grant_active_d = 1'b0;
                  state_d        = S_IDLE;
               end else begin
                  state_d = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = '0;
      if (w_accept) begin
         w_req_ready[grant_id_q] = 1'b1;
      end
   end

   assign bus.req_ready    = w_req_ready;
   assign bus.tx_start     = tx_start_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.grant_active = grant_active_q;
   assign bus.grant_id     = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                    |
// | Self-checking bench: requester byte queues, transmitter model, SB.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 3;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } byte_t;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       last;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic cts;
   logic busy_force;
   int   tx_cnt;

   byte_t src_mem [N][128];
   int    src_wr [N];
   int    src_rd [N];
   int    exp_rd [N];
   logic [1:0] glog [$];

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   int ready_cnt = 0;
   int mon_g;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor, transmitter model and requester drivers all act on the falling edge.
   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         mon_g = int'(bus.grant_id);
         start_cnt++;
         glog.push_back(bus.grant_id);
         chk("start_grant_active", 32'(bus.grant_active), 32'd1);
         if (exp_rd[mon_g] < src_wr[mon_g]) begin
            chk("sb_data", 32'(bus.tx_data), 32'(src_mem[mon_g][exp_rd[mon_g]].data));
            exp_rd[mon_g]++;
         end else begin
            total++;
            bad++;
            $display("FAIL sb_extra: requester %0d sent 0x%0h, required no byte", mon_g, bus.tx_data);
         end
         tx_cnt = FRAME;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
      end
      bus.tx_busy  = busy_force || (tx_cnt > 0);
      bus.uart_cts = cts;
      for (int i = 0; i < N; i++) begin
         if (src_rd[i] < src_wr[i]) begin
            bus.req_valid[i]      = 1'b1;
            bus.req_data[8*i +: 8] = src_mem[i][src_rd[i]].data;
            bus.req_last[i]       = src_mem[i][src_rd[i]].last;
         end else begin
            bus.req_valid[i]      = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
            bus.req_last[i]       = 1'b0;
         end
      end
      #1;
      if (bus.req_ready !== '0) begin
         ready_cnt++;
         chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
         chk("ready_owner", 32'(bus.req_ready), 32'(4'b0001 << bus.grant_id));
         chk("ready_flow", 32'({bus.uart_cts, bus.tx_busy}), 32'd2);
         for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) src_rd[i]++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load(input int id, input int n, input logic [7:0] base, input logic last_end);
      for (int k = 0; k < n; k++) begin
         src_mem[id][src_wr[id]] = '{data: base + 8'(k), last: (last_end && (k == n - 1))};
         src_wr[id]++;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         cyc(1);
         done = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (src_rd[i] != src_wr[i] || exp_rd[i] != src_wr[i]) done = 1'b0;
         end
         if (bus.grant_active !== 1'b0 || tx_cnt != 0 || busy_force) done = 1'b0;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic wait_start(input string name, input int target, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         cyc(1);
         if (start_cnt >= target) ok = 1'b1;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [4];
      int   gb, s0, r0, lat, viol;
      bit   seen;

      vecs[0] = '{id: 0, data: 8'hA5, last: 1'b1, lat: 2};
      vecs[1] = '{id: 3, data: 8'h3C, last: 1'b1, lat: 2};
      vecs[2] = '{id: 1, data: 8'hFF, last: 1'b0, lat: 2};
      vecs[3] = '{id: 2, data: 8'h00, last: 1'b1, lat: 2};

      rst = 1'b1;
      cts = 1'b1;
      busy_force = 1'b0;
      tx_cnt = 0;
      for (int i = 0; i < N; i++) begin
         src_wr[i] = 0;
         src_rd[i] = 0;
         exp_rd[i] = 0;
      end
      cyc(2);
      chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
      chk("rst_grant_active", 32'(bus.grant_active), 32'd0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      cyc(2);

      // Single-byte vectors: latency, data, owner, one ready pulse, release.
      for (int v = 0; v < 4; v++) begin
         r0 = ready_cnt;
         load(vecs[v].id, 1, vecs[v].data, vecs[v].last);
         seen = 1'b0;
         lat = -1;
         for (int k = 1; k <= 10 && !seen; k++) begin
            cyc(1);
            if (bus.tx_start === 1'b1) begin
               seen = 1'b1;
               lat = k;
            end
         end
         chk("vec_latency", 32'(lat), 32'(vecs[v].lat));
         chk("vec_tx_data", 32'(bus.tx_data), 32'(vecs[v].data));
         chk("vec_grant_id", 32'(bus.grant_id), 32'(vecs[v].id));
         wait_idle("vec_idle", 100);
         chk("vec_ready_pulses", 32'(ready_cnt - r0), 32'd1);
         chk("vec_tx_data_hold", 32'(bus.tx_data), 32'(vecs[v].data));
      end

      // All four requesters streaming: bursts of 4 in round-robin order.
      do_reset();
      gb = glog.size();
      for (int i = 0; i < N; i++) load(i, 8, 8'(16 * i + 16), 1'b0);
      wait_idle("rr_idle", 2000);
      chk("rr_count", 32'(glog.size() - gb), 32'd32);
      for (int k = 0; k < 32 && (gb + k) < glog.size(); k++) begin
         chk("rr_order", 32'(glog[gb + k]), 32'((k / 4) % 4));
      end

      // Flow-off mid-message keeps the grant and stalls all accepts.
      gb = glog.size();
      s0 = start_cnt;
      load(2, 6, 8'hC0, 1'b1);
      wait_start("cts_start2", s0 + 2, 100);
      cts = 1'b0;
      s0 = start_cnt;
      r0 = ready_cnt;
      viol = 0;
      for (int c = 0; c < 100; c++) begin
         cyc(1);
         if (bus.grant_id !== 2'd2 || bus.grant_active !== 1'b1 ||
             bus.tx_start !== 1'b0 || bus.req_ready !== '0) viol++;
      end
      chk("cts_hold_viol", 32'(viol), 32'd0);
      chk("cts_no_start", 32'(start_cnt - s0), 32'd0);
      chk("cts_no_ready", 32'(ready_cnt - r0), 32'd0);
      cts = 1'b1;
      wait_idle("cts_idle", 500);
      chk("cts_count", 32'(glog.size() - gb), 32'd6);
      for (int k = 0; k < 6 && (gb + k) < glog.size(); k++) begin
         chk("cts_owner", 32'(glog[gb + k]), 32'd2);
      end

      // Requester 1 runs dry after 2 bytes; next owner is the next valid above 1.
      gb = glog.size();
      s0 = start_cnt;
      load(1, 2, 8'h50, 1'b0);
      wait_start("drop_start1", s0 + 1, 100);
      load(0, 1, 8'h60, 1'b1);
      load(3, 1, 8'h70, 1'b1);
      wait_idle("drop_idle", 500);
      chk("drop_count", 32'(glog.size() - gb), 32'd4);
      if (glog.size() - gb >= 4) begin
         chk("drop_g0", 32'(glog[gb]), 32'd1);
         chk("drop_g1", 32'(glog[gb + 1]), 32'd1);
         chk("drop_g2", 32'(glog[gb + 2]), 32'd3);
         chk("drop_g3", 32'(glog[gb + 3]), 32'd0);
      end

      // Reset in WAIT_DONE: immediate reset values, then requester 0 first.
      s0 = start_cnt;
      load(0, 1, 8'h81, 1'b1);
      load(2, 2, 8'h90, 1'b1);
      wait_start("wd_start", s0 + 1, 100);
      chk("wd_first_owner", 32'(glog[glog.size() - 1]), 32'd2);
      rst = 1'b1;
      #1;
      chk("wd_rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("wd_rst_tx_data", 32'(bus.tx_data), 32'h00);
      chk("wd_rst_grant_active", 32'(bus.grant_active), 32'd0);
      chk("wd_rst_grant_id", 32'(bus.grant_id), 32'd0);
      chk("wd_rst_req_ready", 32'(bus.req_ready), 32'd0);
      cyc(2);
      rst = 1'b0;
      gb = glog.size();
      wait_idle("wd_idle", 500);
      chk("wd_count", 32'(glog.size() - gb), 32'd2);
      if (glog.size() - gb >= 2) begin
         chk("wd_after_g0", 32'(glog[gb]), 32'd0);
         chk("wd_after_g1", 32'(glog[gb + 1]), 32'd2);
      end

      // Transmitter stuck busy: only the first byte may go out.
      s0 = start_cnt;
      r0 = ready_cnt;
      load(3, 2, 8'hE0, 1'b1);
      wait_start("busy_start", s0 + 1, 100);
      busy_force = 1'b1;
      cyc(500);
      chk("busy_one_start", 32'(start_cnt - s0), 32'd1);
      chk("busy_one_ready", 32'(ready_cnt - r0), 32'd1);
      busy_force = 1'b0;
      wait_idle("busy_idle", 200);
      chk("busy_total", 32'(start_cnt - s0), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
